// File: rtl/bin_bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding,
// saturation limit and scratch geometry.
package bin_bcd_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [13:0] BCD_MAX    = 14'd9999;
    localparam int          NUM_DIGITS = 4;
    localparam int          SCRATCH_W  = 4 * NUM_DIGITS;

endpackage

// File: rtl/bin_bcd_converter_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
    input  logic [3:0] digit,
    input  logic       unused_tie,
    output logic [3:0] corrected
);

    logic unused_ok;

    assign corrected = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    assign unused_ok = unused_tie;

endmodule

// File: rtl/bin_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock,
// with saturation at 9999 and BCD outputs held until each conversion completes.
//
//   state | meaning
//   IDLE  | Ready=1, waiting for Start; operand latched on acceptance
//   SHIFT | one correct-and-shift step per clock, BIN_WIDTH steps in total
//   DONE  | scratch copied to BCD3..BCD0 and Overflow, Done pulsed
module bin_bcd_converter
    import bin_bcd_converter_pkg::*;
#(
    parameter int BIN_WIDTH = 14
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [BIN_WIDTH-1:0] Binary,
    output logic                 Ready,
    output logic                 Done,
    output logic                 Overflow,
    output logic [3:0]           BCD3,
    output logic [3:0]           BCD2,
    output logic [3:0]           BCD1,
    output logic [3:0]           BCD0
);

    localparam int                CNT_W    = $clog2(BIN_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BIN_WIDTH - 1);

    state_t                 state;
    state_t                 state_next;
    logic [BIN_WIDTH-1:0]   operand;
    logic [SCRATCH_W-1:0]   scratch;
    logic [SCRATCH_W-1:0]   corrected;
    logic [CNT_W-1:0]       bitcnt;
    logic                   ovf_pend;
    logic                   sat_flag;
    logic [BIN_WIDTH-1:0]   sat_operand;

    // Narrow operands can never exceed 9999, so the compare is elided.
    if (BIN_WIDTH >= 14) begin : g_sat
        assign sat_flag    = (Binary > BIN_WIDTH'(BCD_MAX));
        assign sat_operand = sat_flag ? BIN_WIDTH'(BCD_MAX) : Binary;
    end else begin : g_nosat
        assign sat_flag    = 1'b0;
        assign sat_operand = Binary;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .digit      (scratch[4*g +: 4]),
            .unused_tie (1'b0),
            .corrected  (corrected[4*g +: 4])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (Start) state_next = ST_SHIFT;
            ST_SHIFT: if (bitcnt == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            operand  <= '0;
            scratch  <= '0;
            bitcnt   <= '0;
            ovf_pend <= 1'b0;
            Ready    <= 1'b1;
            Done     <= 1'b0;
            Overflow <= 1'b0;
            BCD3     <= 4'd0;
            BCD2     <= 4'd0;
            BCD1     <= 4'd0;
            BCD0     <= 4'd0;
        end else begin
            state <= state_next;
            Ready <= (state_next == ST_IDLE);
            Done  <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        operand  <= sat_operand;
                        ovf_pend <= sat_flag;
                        scratch  <= '0;
                        bitcnt   <= CNT_LOAD;
                    end
                end
                ST_SHIFT: begin
                    // Digit 3 never reaches 5 after saturation, so its carry-out is always 0.
                    scratch <= (corrected << 1) | SCRATCH_W'(operand[BIN_WIDTH-1]);
                    operand <= operand << 1;
                    if (bitcnt != '0) bitcnt <= bitcnt - 1'b1;
                end
                ST_DONE: begin
                    BCD3     <= scratch[15:12];
                    BCD2     <= scratch[11:8];
                    BCD1     <= scratch[7:4];
                    BCD0     <= scratch[3:0];
                    Overflow <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_bcd_converter.sv
// Directed bench for bin_bcd_converter: latency, saturation, back-to-back
// conversions and asynchronous reset, against hand-computed BCD values.
module tb_bin_bcd_converter;

    localparam int BIN_WIDTH = 14;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 Start;
    logic [BIN_WIDTH-1:0] Binary;
    logic                 Ready;
    logic                 Done;
    logic                 Overflow;
    logic [3:0]           BCD3, BCD2, BCD1, BCD0;
    logic [15:0]          bcd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    bin_bcd_converter #(.BIN_WIDTH(BIN_WIDTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Binary   (Binary),
        .Ready    (Ready),
        .Done     (Done),
        .Overflow (Overflow),
        .BCD3     (BCD3),
        .BCD2     (BCD2),
        .BCD1     (BCD1),
        .BCD0     (BCD0)
    );

    assign bcd = {BCD3, BCD2, BCD1, BCD0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_conv(input string tag, input logic [BIN_WIDTH-1:0] bin,
                            input logic [15:0] exp_bcd, input logic exp_ovf);
        logic [15:0] prev;
        int          lat;
        bit          hold_ok;
        bit          busy_ok;
        prev    = bcd;
        lat     = 0;
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        Binary  = bin;
        Start   = 1'b1;
        tick();
        Start  = 1'b0;
        Binary = ~bin;
        while (!Done && lat < 40) begin
            if (Ready) busy_ok = 1'b0;
            if (bcd !== prev) hold_ok = 1'b0;
            Start = (lat == 3 || lat == 4);
            tick();
            lat++;
        end
        Start = 1'b0;
        check({tag, "_latency"}, lat, 15);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_hold"}, hold_ok, 1);
        check({tag, "_bcd"}, bcd, exp_bcd);
        check({tag, "_ovf"}, Overflow, exp_ovf);
        check({tag, "_ready"}, Ready, 1);
        tick();
        check({tag, "_done_once"}, Done, 0);
        check({tag, "_stable"}, bcd, exp_bcd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          stray;
        int          ndone;
        bit          ready_ok;
        logic [15:0] exp_b2b [3];
        Reset  = 1'b1;
        Start  = 1'b0;
        Binary = '0;
        #1;
        check("rst_bcd", bcd, 16'h0000);
        check("rst_ready", Ready, 1);
        check("rst_done", Done, 0);
        check("rst_ovf", Overflow, 0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        run_conv("c1234", 14'd1234, 16'h1234, 1'b0);

        #2 Reset = 1'b1;
        #1;
        check("async_bcd", bcd, 16'h0000);
        check("async_ready", Ready, 1);
        check("async_done", Done, 0);
        tick();
        Reset = 1'b0;
        tick();

        run_conv("c0", 14'd0, 16'h0000, 1'b0);
        run_conv("c9999", 14'd9999, 16'h9999, 1'b0);
        run_conv("c10000", 14'd10000, 16'h9999, 1'b1);
        run_conv("c16383", 14'd16383, 16'h9999, 1'b1);
        run_conv("c42", 14'd42, 16'h0042, 1'b0);

        // Start held high with Binary = 1000 + 111*c at edge c.
        exp_b2b[0] = 16'h1000;
        exp_b2b[1] = 16'h2776;
        exp_b2b[2] = 16'h4552;
        stray    = 0;
        ready_ok = 1'b1;
        Start    = 1'b1;
        for (int c = 0; c < 48; c++) begin
            Binary = BIN_WIDTH'(1000 + 111 * c);
            tick();
            if (c % 16 == 15) begin
                check($sformatf("b2b%0d_done", c / 16), Done, 1);
                check($sformatf("b2b%0d_bcd", c / 16), bcd, exp_b2b[c / 16]);
            end else begin
                if (Done) stray++;
                if (Ready) ready_ok = 1'b0;
            end
        end
        Start = 1'b0;
        check("b2b_stray_done", stray, 0);
        check("b2b_ready_busy", ready_ok, 1);
        tick();

        Binary = 14'd5678;
        Start  = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #2 Reset = 1'b1;
        #1;
        check("midrst_bcd", bcd, 16'h0000);
        check("midrst_ready", Ready, 1);
        check("midrst_done", Done, 0);
        tick();
        Reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_idle", Ready, 1);
        run_conv("c5678", 14'd5678, 16'h5678, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
